// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply sequencer.
package matmul_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ACC_W  = 18;

   localparam logic [1:0] A_SEL = 2'd0;
   localparam logic [1:0] B_SEL = 2'd1;
   localparam logic [1:0] C_SEL = 2'd2;

   typedef enum logic [2:0] {
      StIdle,
      StRdA,
      StRdB,
      StWr,
      StDone
   } state_e;

endpackage

// File: rtl/matmul_if.sv
// Single-port matrix store bus; the sequencer is the master, the store the slave.
interface matmul_if;
   import matmul_pkg::*;

   logic [1:0]        mem_matrix_select;
   logic [1:0]        mem_row;
   logic [1:0]        mem_col;
   logic              mem_write_enable;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;

   modport master (
      output mem_matrix_select,
      output mem_row,
      output mem_col,
      output mem_write_enable,
      output mem_write_data,
      input  mem_read_data
   );

   modport slave (
      input  mem_matrix_select,
      input  mem_row,
      input  mem_col,
      input  mem_write_enable,
      input  mem_write_data,
      output mem_read_data
   );

endinterface

// File: rtl/mat_mac.sv
// Multiply-accumulate datapath: latches the A element, then accumulates A*B dot products.
module mat_mac
   import matmul_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load_a,
   input  logic              clear_first,
   input  logic              accumulate,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ACC_W-1:0]  acc,
   output logic              acc_over
);

   logic [DATA_W-1:0]   a_q;
   logic [ACC_W-1:0]    acc_q;
   logic [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]    acc_base;

   assign prod     = a_q * rd_data;
   assign acc_base = clear_first ? '0 : acc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q   <= '0;
         acc_q <= '0;
      end else begin
         if (load_a) begin
            a_q <= rd_data;
         end
         if (accumulate) begin
            acc_q <= acc_base + ACC_W'(prod);
         end
      end
   end

   assign acc      = acc_q;
   // Anything above the element range is lost when C is written back.
   assign acc_over = acc_q > ACC_W'({DATA_W{1'b1}});

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer computing C = A x B over the shared 3x3 store; owns the store port while busy.
module matmul_ctrl
   import matmul_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     start,
   output logic     busy,
   output logic     done,
   output logic     overflow,
   matmul_if.master bus
);

   state_e           state_q, state_d;
   logic [1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
   logic             ovf_q, ovf_d;
   logic             load_a, accumulate;
   logic [ACC_W-1:0] acc;
   logic             acc_over;

   mat_mac u_mac (
      .clk         (clk),
      .reset       (reset),
      .load_a      (load_a),
      .clear_first (k_q == 2'd0),
      .accumulate  (accumulate),
      .rd_data     (bus.mem_read_data),
      .acc         (acc),
      .acc_over    (acc_over)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d                = state_q;
      i_d                    = i_q;
      j_d                    = j_q;
      k_d                    = k_q;
      ovf_d                  = ovf_q;
      busy                   = 1'b0;
      done                   = 1'b0;
      load_a                 = 1'b0;
      accumulate             = 1'b0;
      bus.mem_matrix_select  = '0;
      bus.mem_row            = '0;
      bus.mem_col            = '0;
      bus.mem_write_enable   = 1'b0;
      bus.mem_write_data     = '0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRdA;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               ovf_d   = 1'b0;
            end
         end
         StRdA: begin
            busy                  = 1'b1;
            load_a                = 1'b1;
            bus.mem_matrix_select = A_SEL;
            bus.mem_row           = i_q;
            bus.mem_col           = k_q;
            state_d               = StRdB;
         end
         StRdB: begin
            busy                  = 1'b1;
            accumulate            = 1'b1;
            bus.mem_matrix_select = B_SEL;
            bus.mem_row           = k_q;
            bus.mem_col           = j_q;
            if (k_q == 2'd2) begin
               state_d = StWr;
               k_d     = '0;
            end else begin
               state_d = StRdA;
               k_d     = k_q + 2'd1;
            end
         end
         StWr: begin
            busy                  = 1'b1;
            bus.mem_matrix_select = C_SEL;
            bus.mem_row           = i_q;
            bus.mem_col           = j_q;
            bus.mem_write_enable  = 1'b1;
            bus.mem_write_data    = acc[DATA_W-1:0];
            if (acc_over) begin
               ovf_d = 1'b1;
            end
            state_d = StRdA;
            // Row-major walk over C; the last element hands off to DONE.
            if (j_q == 2'd2) begin
               j_d = '0;
               if (i_q == 2'd2) begin
                  i_d     = '0;
                  state_d = StDone;
               end else begin
                  i_d = i_q + 2'd1;
               end
            end else begin
               j_d = j_q + 2'd1;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign overflow = ovf_q;

endmodule
